// File: rtl/wf_slot_tracker_pkg.sv
// -----------------------------------------------------------------------------
// wf_slot_tracker_pkg
//   Shared fetch-stage definitions for the wavefront-slot vacancy tracker:
//   default slot count and widths, the slot-ID and slot-mask typedefs, and a
//   small wrap-around increment helper used by the round-robin pointer.
//   Ports: none (package).
//   Optional feature macro used by importers: WF_SLOT_RR_EN.
// -----------------------------------------------------------------------------
package wf_slot_tracker_pkg;

  localparam int NUM_WF_DEF = 40;  // wavefront slots
  localparam int WFID_W_DEF = 6;   // slot ID width, 2**WFID_W >= NUM_WF
  localparam int CNT_W_DEF  = 7;   // free-count width, 2**CNT_W > NUM_WF

  typedef logic [WFID_W_DEF-1:0] wfid_t;
  typedef logic [NUM_WF_DEF-1:0] wf_mask_t;

  // Next slot index after v, wrapping n-1 back to 0.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage : wf_slot_tracker_pkg

// File: rtl/wf_slot_tracker_if.sv
// -----------------------------------------------------------------------------
// wf_slot_tracker_if
//   Bundles the dispatcher allocation handshake, the retire/halt release path,
//   flush, and the vacancy status the tracker publishes to fetch arbitration.
//   Modports:
//     master : dispatcher / retire side (drives alloc_req, halt, wf_id_done,
//              flush; observes grant and status)
//     slave  : the tracker itself
//   Signals:
//     alloc_req   request a free slot this cycle
//     alloc_gnt   combinational grant
//     alloc_wfid  granted slot ID (valid with alloc_gnt)
//     halt        wavefront retirement strobe
//     wf_id_done  slot being released on halt
//     flush       mark every slot vacant at the next edge
//     vacant      registered vacancy bitmap, 1 = free
//     num_free    registered free-slot count
//     all_busy    registered, no free slots
//     all_vacant  registered, every slot free
//     release_err registered one-cycle pulse on an illegal release
// -----------------------------------------------------------------------------
interface wf_slot_tracker_if
  import wf_slot_tracker_pkg::*;
#(
  parameter int NUM_WF = NUM_WF_DEF,
  parameter int WFID_W = WFID_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              alloc_req;
  logic              alloc_gnt;
  logic [WFID_W-1:0] alloc_wfid;
  logic              halt;
  logic [WFID_W-1:0] wf_id_done;
  logic              flush;
  logic [NUM_WF-1:0] vacant;
  logic [CNT_W-1:0]  num_free;
  logic              all_busy;
  logic              all_vacant;
  logic              release_err;

  modport master (
    output alloc_req, halt, wf_id_done, flush,
    input  alloc_gnt, alloc_wfid, vacant, num_free, all_busy, all_vacant,
           release_err
  );

  modport slave (
    input  alloc_req, halt, wf_id_done, flush,
    output alloc_gnt, alloc_wfid, vacant, num_free, all_busy, all_vacant,
           release_err
  );

endinterface : wf_slot_tracker_if

// File: rtl/wf_find_first_free.sv
// -----------------------------------------------------------------------------
// wf_find_first_free
//   Parametrised find-first-set over an N-bit mask, searching upward from a
//   start index and wrapping modulo N. With start tied to 0 it is a plain
//   lowest-index priority encoder.
//   Ports:
//     mask  in  N      candidate bits (1 = eligible)
//     start in  IDX_W  first index examined; must be < N
//     idx   out IDX_W  first set bit at/after start (0 when none found)
//     found out 1      at least one bit of mask is set
// -----------------------------------------------------------------------------
module wf_find_first_free #(
  parameter int N     = 40,
  parameter int IDX_W = 6
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  int               pos;
  logic [SEL_W-1:0] sel;

  // NOTE: blocking assignments are correct here; this is combinational logic,
  // and found/idx must be updated in loop order so the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(start) + i;
      if (pos >= N) pos = pos - N;
      sel = SEL_W'(pos);
      if (!found && mask[sel]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule : wf_find_first_free

// File: rtl/wf_slot_tracker.sv
// -----------------------------------------------------------------------------
// wf_slot_tracker
//   Registered wavefront-slot vacancy tracker for the fetch stage. Holds the
//   per-slot vacant bitmap, grants free slot IDs to the dispatcher in the same
//   cycle as the request, reclaims slots on wavefront halt, and keeps a
//   registered free count plus full/empty status for fetch arbitration.
//   Ports:
//     clk    in  clock, all state on the rising edge
//     rst_n  in  synchronous active-low reset
//     bus    wf_slot_tracker_if.slave (see interface header for signals)
//   Configuration:
//     WF_SLOT_RR_EN  defined   -> round-robin allocation from a registered
//                                 search pointer (reset/flush to 0)
//                    undefined -> fixed lowest-index allocation, no pointer
// -----------------------------------------------------------------------------
module wf_slot_tracker
  import wf_slot_tracker_pkg::*;
#(
  parameter int NUM_WF = NUM_WF_DEF,
  parameter int WFID_W = WFID_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  wf_slot_tracker_if.slave   bus
);

  localparam logic [NUM_WF-1:0] ONE_HOT0 = NUM_WF'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_WF);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_WF-1:0] vacant_q,      vacant_d;
  logic [CNT_W-1:0]  num_free_q,    num_free_d;
  logic              all_busy_q,    all_busy_d;
  logic              all_vacant_q,  all_vacant_d;
  logic              release_err_q, release_err_d;

  // ---------------------------------------------------------------------------
  // Allocation search
  // ---------------------------------------------------------------------------
  logic [WFID_W-1:0] search_start;
  logic [WFID_W-1:0] ff_idx;
  logic              ff_found;

`ifdef WF_SLOT_RR_EN
  logic [WFID_W-1:0] rr_ptr_q, rr_ptr_d;
  assign search_start = rr_ptr_q;
`else
  assign search_start = '0;
`endif

  wf_find_first_free #(
    .N     (NUM_WF),
    .IDX_W (WFID_W)
  ) u_find_first_free (
    .mask  (vacant_q),
    .start (search_start),
    .idx   (ff_idx),
    .found (ff_found)
  );

  // Grant depends only on the registered busy flag, so it never sees the
  // slot being released this cycle and stays a short combinational path.
  logic alloc_gnt;
  assign alloc_gnt = bus.alloc_req & ~all_busy_q;

  // ---------------------------------------------------------------------------
  // Release qualification
  // ---------------------------------------------------------------------------
  logic              rel_in_range;
  logic [NUM_WF-1:0] rel_onehot;
  logic              rel_already_vacant;
  logic              rel_ok;
  logic [NUM_WF-1:0] rel_mask;
  logic [NUM_WF-1:0] gnt_mask;

  // Shifting a one-hot past the top bit yields zero, so an out-of-range ID
  // never aliases onto a real slot even before the range check gates it.
  assign rel_in_range       = int'(bus.wf_id_done) < NUM_WF;
  assign rel_onehot         = ONE_HOT0 << bus.wf_id_done;
  assign rel_already_vacant = |(vacant_q & rel_onehot);
  assign rel_ok             = bus.halt & rel_in_range & ~rel_already_vacant;
  assign rel_mask           = rel_ok ? rel_onehot : '0;
  assign gnt_mask           = (alloc_gnt && ff_found) ? (ONE_HOT0 << ff_idx) : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    vacant_d      = vacant_q;
    num_free_d    = num_free_q;
    release_err_d = 1'b0;
    if (bus.flush) begin
      // Flush wins: any concurrent grant is dropped and halt is not judged.
      vacant_d   = '1;
      num_free_d = CNT_FULL;
    end else begin
      vacant_d      = (vacant_q & ~gnt_mask) | rel_mask;
      num_free_d    = num_free_q + CNT_W'(rel_ok) - CNT_W'(alloc_gnt);
      release_err_d = bus.halt & ~rel_ok;
    end
    all_busy_d   = (num_free_d == '0);
    all_vacant_d = (num_free_d == CNT_FULL);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the vacancy bitmap is a plain flop vector, not a memory, so it is
  // reset in full like any other control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vacant_q      <= '1;
      num_free_q    <= CNT_FULL;
      all_busy_q    <= 1'b0;
      all_vacant_q  <= 1'b1;
      release_err_q <= 1'b0;
    end else begin
      vacant_q      <= vacant_d;
      num_free_q    <= num_free_d;
      all_busy_q    <= all_busy_d;
      all_vacant_q  <= all_vacant_d;
      release_err_q <= release_err_d;
    end
  end

`ifdef WF_SLOT_RR_EN
  // Pointer moves just past each granted slot so the next search starts there.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (bus.flush) begin
      rr_ptr_d = '0;
    end else if (alloc_gnt && ff_found) begin
      rr_ptr_d = WFID_W'(wrap_inc(int'(ff_idx), NUM_WF));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.alloc_gnt   = alloc_gnt;
  assign bus.alloc_wfid  = ff_found ? ff_idx : '0;
  assign bus.vacant      = vacant_q;
  assign bus.num_free    = num_free_q;
  assign bus.all_busy    = all_busy_q;
  assign bus.all_vacant  = all_vacant_q;
  assign bus.release_err = release_err_q;

  // The count is kept incrementally; it must always agree with the bitmap.
  a_free_count_matches: assert property (
    @(posedge clk) disable iff (!rst_n)
      num_free_q == CNT_W'($countones(vacant_q))
  );

endmodule : wf_slot_tracker

// File: tb/tb_wf_slot_tracker.sv
// -----------------------------------------------------------------------------
// tb_wf_slot_tracker
//   Directed, table-driven bench for wf_slot_tracker (40 slots). Inputs are
//   driven on the falling edge; combinational grant outputs are sampled 1 ns
//   later and registered state 1 ns after the rising edge.
//   Round-robin checks are compiled when WF_SLOT_RR_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wf_slot_tracker;
  import wf_slot_tracker_pkg::*;

  localparam int NW = 40;
  localparam logic [39:0] ALL1 = {40{1'b1}};

  logic clk;
  logic rst_n;

  wf_slot_tracker_if #(.NUM_WF(40), .WFID_W(6), .CNT_W(7)) bus ();

  wf_slot_tracker #(.NUM_WF(40), .WFID_W(6), .CNT_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec     = 0;
  int n_miscmp  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic req, input logic hlt,
                       input logic [5:0] id, input logic fl);
    @(negedge clk);
    bus.alloc_req  = req;
    bus.halt       = hlt;
    bus.wf_id_done = id;
    bus.flush      = fl;
    #1;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, 6'd0, 1'b0);
    rst_n = 1'b0;
    settle();
    settle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Allocate n slots back-to-back from the current state, expecting IDs
  // first, first+1, ...
  task automatic alloc_run(input int first, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      apply(1'b1, 1'b0, 6'd0, 1'b0);
      check($sformatf("%s_gnt%0d", tag, first + i), 64'(bus.alloc_gnt), 64'd1);
      check($sformatf("%s_wfid%0d", tag, first + i), 64'(bus.alloc_wfid),
            64'(first + i));
      settle();
    end
  endtask

  typedef struct {
    logic        req;
    logic        hlt;
    logic [5:0]  id;
    logic        fl;
    logic        exp_gnt;
    logic [5:0]  exp_wfid;
    logic [39:0] exp_vac;
    logic [6:0]  exp_free;
    logic        exp_busy;
    logic        exp_allvac;
    logic        exp_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alloc_req  = 1'b0;
    bus.halt       = 1'b0;
    bus.wf_id_done = '0;
    bus.flush      = 1'b0;
    rst_n          = 1'b0;

    // Table starts from the all-busy state reached by the 40-grant run.
    //          req hlt id  fl  gnt wfid vacant              free busy allv err
    tbl[0] = '{1'b0, 1'b1, 6'd17, 1'b0, 1'b0, 6'd0,  40'd1 << 17, 7'd1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 6'd17, 40'd0,       7'd0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 6'd3,  1'b0, 1'b0, 6'd0,  40'd1 << 3,  7'd1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 6'd2,  1'b0, 1'b1, 6'd3,  40'd1 << 2,  7'd1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 6'd5,  1'b0, 1'b0, 6'd2,  40'h24,      7'd2, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 6'd5,  1'b0, 1'b0, 6'd2,  40'h24,      7'd2, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 6'd2,  40'h24,      7'd2, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 6'd45, 1'b0, 1'b0, 6'd2,  40'h24,      7'd2, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 6'd45, 1'b0, 1'b1, 6'd2,  40'h20,      7'd1, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 6'd2,  1'b0, 1'b1, 6'd5,  40'h04,      7'd1, 1'b0, 1'b0, 1'b0};

    // ---- reset state ------------------------------------------------------
    do_reset();
    #1;
    check("rst_vacant",   64'(bus.vacant),      64'(ALL1));
    check("rst_num_free", 64'(bus.num_free),    64'd40);
    check("rst_all_busy", 64'(bus.all_busy),    64'd0);
    check("rst_all_vac",  64'(bus.all_vacant),  64'd1);
    check("rst_rel_err",  64'(bus.release_err), 64'd0);

    // ---- 40 consecutive grants, then a refused 41st -----------------------
    for (int i = 0; i < NW; i++) begin
      apply(1'b1, 1'b0, 6'd0, 1'b0);
      check($sformatf("fill_gnt%0d", i),  64'(bus.alloc_gnt),  64'd1);
      check($sformatf("fill_wfid%0d", i), 64'(bus.alloc_wfid), 64'(i));
      settle();
      check($sformatf("fill_free%0d", i), 64'(bus.num_free), 64'(NW - 1 - i));
    end
    check("full_busy",   64'(bus.all_busy), 64'd1);
    check("full_vacant", 64'(bus.vacant),   64'd0);
    apply(1'b1, 1'b0, 6'd0, 1'b0);
    check("req41_gnt",  64'(bus.alloc_gnt),  64'd0);
    check("req41_wfid", 64'(bus.alloc_wfid), 64'd0);
    settle();
    check("req41_free", 64'(bus.num_free), 64'd0);

`ifndef WF_SLOT_RR_EN
    // ---- table: reclaim, same-cycle alloc+release, illegal releases -------
    for (int t = 0; t < 10; t++) begin
      apply(tbl[t].req, tbl[t].hlt, tbl[t].id, tbl[t].fl);
      check($sformatf("t%0d_gnt", t),  64'(bus.alloc_gnt),  64'(tbl[t].exp_gnt));
      check($sformatf("t%0d_wfid", t), 64'(bus.alloc_wfid), 64'(tbl[t].exp_wfid));
      settle();
      check($sformatf("t%0d_vacant", t), 64'(bus.vacant),      64'(tbl[t].exp_vac));
      check($sformatf("t%0d_free", t),   64'(bus.num_free),    64'(tbl[t].exp_free));
      check($sformatf("t%0d_busy", t),   64'(bus.all_busy),    64'(tbl[t].exp_busy));
      check($sformatf("t%0d_allvac", t), 64'(bus.all_vacant),  64'(tbl[t].exp_allvac));
      check($sformatf("t%0d_err", t),    64'(bus.release_err), 64'(tbl[t].exp_err));
    end
`endif

    // ---- flush with concurrent alloc and an illegal halt ------------------
    do_reset();
    alloc_run(0, 20, "pre_flush");
    apply(1'b1, 1'b1, 6'd30, 1'b1);
    check("flush_gnt",  64'(bus.alloc_gnt),  64'd1);
    check("flush_wfid", 64'(bus.alloc_wfid), 64'd20);
    settle();
    check("flush_vacant", 64'(bus.vacant),      64'(ALL1));
    check("flush_free",   64'(bus.num_free),    64'd40);
    check("flush_allvac", 64'(bus.all_vacant),  64'd1);
    check("flush_busy",   64'(bus.all_busy),    64'd0);
    check("flush_err",    64'(bus.release_err), 64'd0);
    alloc_run(0, 3, "post_flush");
    check("post_flush_free", 64'(bus.num_free), 64'd37);

    // ---- synchronous reset mid-operation overrides other inputs -----------
    apply(1'b1, 1'b1, 6'd60, 1'b0);
    rst_n = 1'b0;
    settle();
    check("midrst_vacant", 64'(bus.vacant),      64'(ALL1));
    check("midrst_free",   64'(bus.num_free),    64'd40);
    check("midrst_allvac", 64'(bus.all_vacant),  64'd1);
    check("midrst_err",    64'(bus.release_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.halt = 1'b0;
    #1;
    check("midrst_gnt",  64'(bus.alloc_gnt),  64'd1);
    check("midrst_wfid", 64'(bus.alloc_wfid), 64'd0);
    settle();
    check("midrst_free2", 64'(bus.num_free), 64'd39);

`ifdef WF_SLOT_RR_EN
    // ---- round robin: skip a freshly released low slot, then wrap ---------
    do_reset();
    alloc_run(0, 3, "rr_a");
    apply(1'b0, 1'b1, 6'd0, 1'b0);
    settle();
    check("rr_rel0_free", 64'(bus.num_free), 64'd38);
    alloc_run(3, 37, "rr_b");
    apply(1'b1, 1'b0, 6'd0, 1'b0);
    check("rr_wrap_gnt",  64'(bus.alloc_gnt),  64'd1);
    check("rr_wrap_wfid", 64'(bus.alloc_wfid), 64'd0);
    settle();
    check("rr_wrap_free", 64'(bus.num_free), 64'd0);
    check("rr_wrap_busy", 64'(bus.all_busy), 64'd1);
`endif

    apply(1'b0, 1'b0, 6'd0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule : tb_wf_slot_tracker
